// File: rtl/character_reader_if.sv
// rtl/character_reader_if.sv - request, buffer-read and character-stream bundle for character_reader
interface character_reader_if;
  logic       request_ready;
  logic       request_valid;
  logic [4:0] request_row;
  logic [6:0] request_col;
  logic [7:0] request_count;
  logic       read_ready;
  logic       read_valid;
  logic [4:0] read_row;
  logic [6:0] read_col;
  logic       read_data_valid;
  logic [7:0] read_data;
  logic       character_ready;
  logic       character_valid;
  logic [7:0] character_byte;

  modport master (
    output request_ready,
    input  request_valid, request_row, request_col, request_count,
    input  read_ready,
    output read_valid, read_row, read_col,
    input  read_data_valid, read_data,
    input  character_ready,
    output character_valid, character_byte
  );

  modport slave (
    input  request_ready,
    output request_valid, request_row, request_col, request_count,
    output read_ready,
    input  read_valid, read_row, read_col,
    output read_data_valid, read_data,
    output character_ready,
    input  character_valid, character_byte
  );
endinterface

// File: rtl/character_reader.sv
// rtl/character_reader.sv - credit-limited character buffer reader; CHARACTER_READER_NEWLINE_EN adds 0A after each end-of-row byte
module character_reader #(
  parameter int COLS  = 100,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_low,
  character_reader_if.master  bus,
  output logic                busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state;
  logic [4:0]      row;
  logic [6:0]      col;
  logic [7:0]      remaining;
  logic            read_valid_q;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   fifo_count_next;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      fifo_mem [DEPTH];

  logic read_fire;
  logic resp_ok;
  logic fifo_pop;
  logic char_valid;
  logic char_fire;
  logic at_row_end;
  logic credit_ok;
  logic nl_next;

`ifdef CHARACTER_READER_NEWLINE_EN
  // End-of-row tags travel with in-flight reads (ring) and then with FIFO entries.
  logic            tag_ring [DEPTH];
  logic            fifo_tag [DEPTH];
  logic [PW-1:0]   tag_wr;
  logic [PW-1:0]   tag_rd;
  logic            nl_pending;
`endif

  assign read_fire  = read_valid_q & bus.read_ready;
  assign resp_ok    = bus.read_data_valid & (outstanding != '0);
  assign at_row_end = (col == LAST_COL);
  assign char_fire  = char_valid & bus.character_ready;

`ifdef CHARACTER_READER_NEWLINE_EN
  assign char_valid = nl_pending | (fifo_count != '0);
  assign bus.character_byte = nl_pending ? 8'h0A :
                              ((fifo_count != '0) ? fifo_mem[rd_ptr] : 8'h00);
  assign fifo_pop   = char_fire & ~nl_pending;
  assign nl_next    = nl_pending ? ~char_fire : (fifo_pop & fifo_tag[rd_ptr]);
`else
  assign char_valid = (fifo_count != '0);
  assign bus.character_byte = (fifo_count != '0) ? fifo_mem[rd_ptr] : 8'h00;
  assign fifo_pop   = char_fire;
  assign nl_next    = 1'b0;
`endif

  assign outstanding_next = outstanding + CW'(read_fire) - CW'(resp_ok);
  assign fifo_count_next  = fifo_count + CW'(resp_ok) - CW'(fifo_pop);
  // Evaluated on post-edge occupancy; that sum can only grow through a
  // read handshake, so a raised read_valid never loses its credit.
  assign credit_ok = ({1'b0, outstanding_next} + {1'b0, fifo_count_next}) < DEPTH_V;

  assign bus.character_valid = char_valid;
  assign bus.request_ready   = (state == IDLE);
  assign bus.read_valid      = read_valid_q;
  assign bus.read_row        = row;
  assign bus.read_col        = col;
  assign busy                = (state != IDLE);

  // Control FSM, address walk, credit counters and FIFO pointers.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      remaining    <= '0;
      read_valid_q <= 1'b0;
      outstanding  <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
`ifdef CHARACTER_READER_NEWLINE_EN
      tag_wr       <= '0;
      tag_rd       <= '0;
      nl_pending   <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding_next;
      fifo_count  <= fifo_count_next;
      if (resp_ok)  wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
`ifdef CHARACTER_READER_NEWLINE_EN
      if (read_fire) tag_wr <= tag_wr + PW'(1);
      if (resp_ok)   tag_rd <= tag_rd + PW'(1);
      nl_pending <= nl_next;
`endif
      case (state)
        IDLE: begin
          if (bus.request_valid) begin
            row       <= bus.request_row;
            col       <= bus.request_col;
            remaining <= bus.request_count;
            if (bus.request_count != 8'd0) begin
              state        <= READ;
              read_valid_q <= credit_ok;
            end else begin
              state <= DRAIN;
            end
          end
        end
        READ: begin
          if (read_fire) begin
            remaining <= remaining - 8'd1;
            if (at_row_end) begin
              col <= 7'd0;
              row <= row + 5'd1;
            end else begin
              col <= col + 7'd1;
            end
          end
          if (read_fire && remaining == 8'd1) begin
            state        <= DRAIN;
            read_valid_q <= 1'b0;
          end else begin
            read_valid_q <= credit_ok;
          end
        end
        DRAIN: begin
          if (outstanding_next == '0 && fifo_count_next == '0 && !nl_next)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage (and in-flight tags) need no reset: count and pointers gate them.
  always_ff @(posedge clk) begin
    if (resp_ok) fifo_mem[wr_ptr] <= bus.read_data;
`ifdef CHARACTER_READER_NEWLINE_EN
    if (resp_ok)   fifo_tag[wr_ptr] <= tag_ring[tag_rd];
    if (read_fire) tag_ring[tag_wr] <= at_row_end;
`endif
  end

endmodule
